// File: rtl/dht11_driver_if.sv
// Host-side request/result bundle of the DHT11 single-wire reader.
interface dht11_driver_if;
    logic        enable;
    logic [39:0] sensor_data;
    logic        error;
    logic        dadosOK;

    modport master (output enable, input sensor_data, input error, input dadosOK);
    modport slave  (input enable, output sensor_data, output error, output dadosOK);
endinterface

// File: rtl/dht11_driver.sv
// DHT11 reader: issues the host start pulse on an open-drain line, then times
// the sensor's response and 40 data bits, publishing only complete frames.
module dht11_driver #(
    parameter int START_CYCLES   = 1_000_000,
    parameter int BIT_THRESHOLD  = 2_000,
    parameter int TIMEOUT_CYCLES = 10_000
) (
    input  logic              clock,
    input  logic              reset_n,
    inout  wire               transmission_line,
    dht11_driver_if.slave     bus
);

    localparam int CNT_MAX = (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W:0]   THRESH     = (CNT_W+1)'(BIT_THRESHOLD);
    localparam logic [CNT_W-1:0] SYNC_BLANK = CNT_W'(2);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_START_LOW = 4'd1;
    localparam logic [3:0] S_WAIT_RESP = 4'd2;
    localparam logic [3:0] S_RESP_LOW  = 4'd3;
    localparam logic [3:0] S_RESP_HIGH = 4'd4;
    localparam logic [3:0] S_BIT_LOW   = 4'd5;
    localparam logic [3:0] S_BIT_HIGH  = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_FAIL      = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       bit_idx_q, bit_idx_d;
    logic [39:0]      shift_q, shift_d;
    logic [39:0]      data_q, data_d;
    logic             error_q, error_d;
    logic             ok_q, ok_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;

    logic             line_s;
    logic             tmo;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W:0]   hi_len;
    logic             bit_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign line_s  = sync2_q;
    assign cnt_inc = sat_inc(cnt_q);
    assign tmo     = (cnt_q >= TMO_LAST);
    // Pulse length counts the cycle that detected the rising edge as well.
    assign hi_len  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign bit_val = (hi_len > THRESH);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        error_d   = error_q;
        ok_d      = ok_q;
        sync1_d   = transmission_line;
        sync2_d   = sync1_q;

        if (!bus.enable && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            error_d = 1'b0;
            ok_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.enable) begin
                        state_d   = S_START_LOW;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        error_d   = 1'b0;
                        ok_d      = 1'b0;
                    end
                end
                S_START_LOW: begin
                    if (cnt_q >= START_LAST) begin
                        state_d = S_WAIT_RESP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // The synchronizer still holds our own start-low for two cycles after release.
                S_WAIT_RESP: begin
                    if (!line_s && cnt_q >= SYNC_BLANK) begin
                        state_d = S_RESP_LOW;
                        cnt_d   = '0;
                    end else if (tmo) begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RESP_LOW: begin
                    if (line_s) begin
                        state_d = S_RESP_HIGH;
                        cnt_d   = '0;
                    end else if (tmo) begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_RESP_HIGH: begin
                    if (!line_s) begin
                        state_d = S_BIT_LOW;
                        cnt_d   = '0;
                    end else if (tmo) begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_BIT_LOW: begin
                    if (line_s) begin
                        state_d = S_BIT_HIGH;
                        cnt_d   = '0;
                    end else if (tmo) begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_BIT_HIGH: begin
                    if (!line_s) begin
                        shift_d   = {shift_q[38:0], bit_val};
                        bit_idx_d = bit_idx_q + 6'd1;
                        cnt_d     = '0;
                        if (bit_idx_q == 6'd39) begin
                            data_d  = {shift_q[38:0], bit_val};
                            ok_d    = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_BIT_LOW;
                        end
                    end else if (tmo) begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                S_DONE, S_FAIL: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            error_q   <= 1'b0;
            ok_q      <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            error_q   <= error_d;
            ok_q      <= ok_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    // Open-drain: pull low only from the registered state so reset releases at once.
    assign transmission_line = (state_q == S_START_LOW) ? 1'b0 : 1'bz;

    assign bus.sensor_data = data_q;
    assign bus.error       = error_q;
    assign bus.dadosOK     = ok_q;

endmodule

// File: tb/tb_dht11_driver.sv
// Directed bench for dht11_driver with a pulled-up line and a behavioural sensor.
module tb_dht11_driver;

    localparam int START_C = 100;
    localparam int THR_C   = 20;
    localparam int TMO_C   = 100;

    logic clk;
    logic reset_n;
    logic model_low;
    logic allow_host_low;
    wire  line;
    int   total;
    int   bad;
    int   stray;

    dht11_driver_if bus();

    pullup (line);
    assign line = model_low ? 1'b0 : 1'bz;

    dht11_driver #(
        .START_CYCLES  (START_C),
        .BIT_THRESHOLD (THR_C),
        .TIMEOUT_CYCLES(TMO_C)
    ) dut (
        .clock            (clk),
        .reset_n          (reset_n),
        .transmission_line(line),
        .bus              (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any low the sensor model is not causing must fall inside an expected start pulse.
    always @(negedge clk) begin
        if (reset_n && line === 1'b0 && !model_low && !allow_host_low)
            stray = stray + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h required=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start_release();
        int n;
        n = 0;
        while (line !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", line, 1'b0);
        n = 0;
        while (line !== 1'b1 && n < START_C + 50) begin
            @(negedge clk);
            n++;
        end
        chk("release_seen", line, 1'b1);
        allow_host_low = 1'b0;
    endtask

    task automatic start_read();
        allow_host_low = 1'b1;
        bus.enable = 1'b1;
    endtask

    task automatic sensor_reply(input logic [39:0] frame, input int h0, input int h1,
                                input int abort_bit);
        wait_start_release();
        wait_cyc(5);
        model_low = 1'b1;
        wait_cyc(80);
        model_low = 1'b0;
        wait_cyc(80);
        for (int i = 39; i >= 0; i--) begin
            model_low = 1'b1;
            if (39 - i == abort_bit) begin
                wait_cyc(10);
                bus.enable = 1'b0;
                model_low  = 1'b0;
                return;
            end
            wait_cyc(50);
            model_low = 1'b0;
            wait_cyc(frame[i] ? h1 : h0);
        end
        model_low = 1'b1;
        wait_cyc(50);
        model_low = 1'b0;
        wait_cyc(5);
    endtask

    initial begin
        int n;
        int lows;
        total          = 0;
        bad            = 0;
        stray          = 0;
        model_low      = 1'b0;
        allow_host_low = 1'b0;
        bus.enable     = 1'b0;
        reset_n        = 1'b0;
        wait_cyc(3);
        chk("rst_data", bus.sensor_data, 40'h0);
        chk("rst_error", bus.error, 1'b0);
        chk("rst_ok", bus.dadosOK, 1'b0);
        chk("rst_line", line, 1'b1);
        reset_n = 1'b1;
        wait_cyc(2);

        // Normal read
        start_read();
        sensor_reply(40'h3700190050, 14, 35, -1);
        chk("norm_data", bus.sensor_data, 40'h3700190050);
        chk("norm_ok", bus.dadosOK, 1'b1);
        chk("norm_err", bus.error, 1'b0);

        // Enable held high after DONE must not restart
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (line === 1'b0) lows++;
        end
        chk("hold_no_restart", lows, 0);
        chk("hold_ok", bus.dadosOK, 1'b1);
        bus.enable = 1'b0;
        @(posedge clk); #1;
        chk("done_clear_ok", bus.dadosOK, 1'b0);
        chk("done_keep_data", bus.sensor_data, 40'h3700190050);
        wait_cyc(3);

        // Threshold edge: 20 high decodes 0, 21 decodes 1
        start_read();
        sensor_reply(40'hA53C0FF081, THR_C, THR_C + 1, -1);
        chk("thr_data", bus.sensor_data, 40'hA53C0FF081);
        chk("thr_ok", bus.dadosOK, 1'b1);
        bus.enable = 1'b0;
        wait_cyc(3);

        // Abort during bit 10
        start_read();
        sensor_reply(40'h123456789A, 14, 35, 10);
        @(posedge clk); #1;
        chk("abort_ok", bus.dadosOK, 1'b0);
        chk("abort_err", bus.error, 1'b0);
        chk("abort_line", line, 1'b1);
        chk("abort_keep_data", bus.sensor_data, 40'hA53C0FF081);
        wait_cyc(5);

        // No response
        start_read();
        wait_start_release();
        n = 0;
        while (!bus.error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("noresp_cycles", n, TMO_C);
        chk("noresp_err", bus.error, 1'b1);
        chk("noresp_ok", bus.dadosOK, 1'b0);
        chk("noresp_keep_data", bus.sensor_data, 40'hA53C0FF081);
        bus.enable = 1'b0;
        @(posedge clk); #1;
        chk("fail_clear_err", bus.error, 1'b0);
        wait_cyc(3);

        // Stuck low after response start
        start_read();
        wait_start_release();
        wait_cyc(5);
        model_low = 1'b1;
        n = 0;
        while (!bus.error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("stuck_cycles", n, TMO_C + 3);
        chk("stuck_ok", bus.dadosOK, 1'b0);
        chk("stuck_keep_data", bus.sensor_data, 40'hA53C0FF081);
        bus.enable = 1'b0;
        model_low  = 1'b0;
        wait_cyc(3);

        // Reset in the middle of the start pulse
        start_read();
        wait_cyc(30);
        chk("mid_start_low", line, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_line", line, 1'b1);
        chk("rst_mid_data", bus.sensor_data, 40'h0);
        chk("rst_mid_err", bus.error, 1'b0);
        chk("rst_mid_ok", bus.dadosOK, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (line !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        lows = 0;
        while (line === 1'b0 && lows < 300) begin
            @(negedge clk);
            lows++;
        end
        chk("fresh_pulse_len", lows, START_C);
        allow_host_low = 1'b0;
        n = 0;
        while (!bus.error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("fresh_fail_err", bus.error, 1'b1);
        bus.enable = 1'b0;
        wait_cyc(3);

        chk("no_stray_drive", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
